// File: rtl/aes_io_ctrl_if.sv
// Host-side byte bus and core-side block bus of the AES I/O controller.
// master is the host/core environment; slave is the controller itself.
interface aes_io_ctrl_if #(
  parameter int NBYTES = 16
);
  logic [1:0]          CMD;
  logic [7:0]          DIN;
  logic                READY;
  logic                OK;
  logic [7:0]          DOUT;
  logic [8*NBYTES-1:0] key;
  logic                key_ld;
  logic [8*NBYTES-1:0] blk;
  logic                start;
  logic                done;
  logic [8*NBYTES-1:0] res;

  modport master (
    output CMD, DIN, done, res,
    input  READY, OK, DOUT, key, key_ld, blk, start
  );

  modport slave (
    input  CMD, DIN, done, res,
    output READY, OK, DOUT, key, key_ld, blk, start
  );
endinterface

// File: rtl/aes_io_ctrl.sv
// Byte-serial host controller for the AES core: assembles key/data blocks
// from DIN, launches the core, captures the result and streams it on DOUT.
module aes_io_ctrl #(
  parameter int NBYTES = 16
) (
  input  logic         CLK,
  input  logic         RST_,
  aes_io_ctrl_if.slave io
);
  localparam int BW = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_KEY  = 2'b01;
  localparam logic [1:0] CMD_DATA = 2'b10;
  localparam logic [1:0] CMD_READ = 2'b11;

  typedef enum logic [2:0] {IDLE, LDKEY, LDDATA, START, BUSY, RD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [BW-1:0] key_r, blk_r, res_r;
  logic [7:0]    dout_r;
  logic          ok, kv, key_ld_r, start_r;

  logic key_we, blk_we, dout_we, res_we;
  logic ok_set, ok_clr, kv_set, key_ld_nxt, start_nxt;

  // Byte k sits at the MSB end shifted down by k bytes (byte 0 is the MSB).
  function automatic logic [7:0] get_byte(input logic [BW-1:0] v,
                                          input logic [CW-1:0] k);
    logic [BW-1:0] sh;
    sh = v << {k, 3'b000};
    return sh[BW-1 -: 8];
  endfunction

  function automatic logic [BW-1:0] put_byte(input logic [BW-1:0] v,
                                             input logic [CW-1:0] k,
                                             input logic [7:0]    d);
    logic [BW-1:0] mask, data;
    mask = {8'hFF, {(BW-8){1'b0}}} >> {k, 3'b000};
    data = {d,     {(BW-8){1'b0}}} >> {k, 3'b000};
    return (v & ~mask) | data;
  endfunction

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state    <= IDLE;
      cnt      <= '0;
      ok       <= 1'b0;
      kv       <= 1'b0;
      key_ld_r <= 1'b0;
      start_r  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      key_ld_r <= key_ld_nxt;
      start_r  <= start_nxt;
      if (kv_set) kv <= 1'b1;
      if (ok_set)      ok <= 1'b1;
      else if (ok_clr) ok <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      key_r  <= '0;
      blk_r  <= '0;
      res_r  <= '0;
      dout_r <= '0;
    end else begin
      if (key_we)  key_r  <= put_byte(key_r, cnt, io.DIN);
      if (blk_we)  blk_r  <= put_byte(blk_r, cnt, io.DIN);
      if (res_we)  res_r  <= io.res;
      if (dout_we) dout_r <= get_byte(res_r, cnt);
    end
  end

  // cnt is always 0 in IDLE, so it doubles as the byte index on every path.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    key_we     = 1'b0;
    blk_we     = 1'b0;
    dout_we    = 1'b0;
    res_we     = 1'b0;
    ok_set     = 1'b0;
    ok_clr     = 1'b0;
    kv_set     = 1'b0;
    key_ld_nxt = 1'b0;
    case (state)
      IDLE: begin
        case (io.CMD)
          CMD_KEY: begin
            key_we    = 1'b1;
            cnt_nxt   = CW'(1);
            state_nxt = LDKEY;
          end
          CMD_DATA: begin
            blk_we    = 1'b1;
            cnt_nxt   = CW'(1);
            state_nxt = LDDATA;
          end
          CMD_READ: begin
            if (ok) begin
              dout_we   = 1'b1;
              cnt_nxt   = CW'(1);
              state_nxt = RD;
            end
          end
          default: ;
        endcase
      end
      LDKEY: begin
        if (io.CMD == CMD_KEY) begin
          key_we = 1'b1;
          if (cnt == LAST) begin
            key_ld_nxt = 1'b1;
            kv_set     = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else if (io.CMD != CMD_NOP) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      LDDATA: begin
        if (io.CMD == CMD_DATA) begin
          blk_we = 1'b1;
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = kv ? START : IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else if (io.CMD != CMD_NOP) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      START: state_nxt = BUSY;
      BUSY: begin
        if (io.done) begin
          res_we    = 1'b1;
          ok_set    = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD: begin
        if (io.CMD == CMD_READ) begin
          dout_we = 1'b1;
          if (cnt == LAST) begin
            ok_clr    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else if (io.CMD != CMD_NOP) begin
          // Aborted read keeps OK so the host can restart from byte 0.
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
    start_nxt = (state_nxt == START);
  end

  assign io.READY  = (state == IDLE) || (state == LDKEY) ||
                     (state == LDDATA) || (state == RD);
  assign io.OK     = ok;
  assign io.DOUT   = dout_r;
  assign io.key    = key_r;
  assign io.key_ld = key_ld_r;
  assign io.blk    = blk_r;
  assign io.start  = start_r;
endmodule

// File: tb/tb_aes_io_ctrl.sv
// Directed testbench for aes_io_ctrl: load, launch, read, abort and reset cases.
module tb_aes_io_ctrl;
  localparam int NB = 16;

  logic CLK = 1'b0;
  logic RST_ = 1'b0;
  int   total = 0;
  int   passed = 0;

  aes_io_ctrl_if #(.NBYTES(NB)) io();

  aes_io_ctrl #(.NBYTES(NB)) dut (
    .CLK (CLK),
    .RST_(RST_),
    .io  (io.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    io.CMD = 2'b11; io.DIN = 8'h00; io.done = 1'b0; io.res = '0;
    RST_ = 1'b0;
    repeat (2) tick();
    total++; if (io.READY !== 1'b1) $display("FAIL rst_ready got %b exp 1", io.READY); else passed++;
    total++; if (io.OK !== 1'b0) $display("FAIL rst_ok got %b exp 0", io.OK); else passed++;
    total++; if (io.DOUT !== 8'h00) $display("FAIL rst_dout got %h exp 00", io.DOUT); else passed++;
    total++; if (io.key !== '0 || io.blk !== '0) $display("FAIL rst_regs key %h blk %h exp 0", io.key, io.blk); else passed++;
    total++; if (io.start !== 1'b0 || io.key_ld !== 1'b0) $display("FAIL rst_pulses start %b key_ld %b exp 0", io.start, io.key_ld); else passed++;
    RST_ = 1'b1;
    tick();
    total++; if (io.OK !== 1'b0 || io.DOUT !== 8'h00) $display("FAIL read_no_ok ok %b dout %h exp 0/00", io.OK, io.DOUT); else passed++;
    io.CMD = 2'b00;
    tick();
    total++; if (io.READY !== 1'b1) $display("FAIL read_no_ok_ready got %b exp 1", io.READY); else passed++;
  endtask

  task automatic test_full_block();
    int kl = 0;
    int st = 0;
    for (int i = 0; i < NB; i++) begin
      io.CMD = 2'b01; io.DIN = 8'(i);
      tick();
      if (io.key_ld === 1'b1) kl++;
    end
    io.CMD = 2'b00;
    tick();
    if (io.key_ld === 1'b1) kl++;
    total++; if (kl != 1) $display("FAIL key_ld_count got %0d exp 1", kl); else passed++;
    total++; if (io.key !== 128'h000102030405060708090A0B0C0D0E0F) $display("FAIL key_value got %h", io.key); else passed++;
    for (int i = 0; i < NB; i++) begin
      io.CMD = 2'b10; io.DIN = 8'(16 + i);
      tick();
      if (io.start === 1'b1) st++;
    end
    total++; if (io.start !== 1'b1) $display("FAIL start_timing got %b exp 1", io.start); else passed++;
    total++; if (io.READY !== 1'b0) $display("FAIL start_ready got %b exp 0", io.READY); else passed++;
    total++; if (io.blk !== 128'h101112131415161718191A1B1C1D1E1F) $display("FAIL blk_value got %h", io.blk); else passed++;
    io.CMD = 2'b00;
    repeat (3) begin
      tick();
      if (io.start === 1'b1) st++;
    end
    total++; if (st != 1) $display("FAIL start_count got %0d exp 1", st); else passed++;
    total++; if (io.READY !== 1'b0) $display("FAIL busy_ready got %b exp 0", io.READY); else passed++;
    io.res = {16{8'hA5}}; io.done = 1'b1;
    tick();
    io.done = 1'b0;
    total++; if (io.OK !== 1'b1 || io.READY !== 1'b1) $display("FAIL done_ok ok %b ready %b exp 1/1", io.OK, io.READY); else passed++;
  endtask

  task automatic test_read();
    for (int i = 0; i < NB; i++) begin
      io.CMD = 2'b11;
      tick();
      total++; if (io.DOUT !== 8'hA5) $display("FAIL read_a5[%0d] got %h exp a5", i, io.DOUT); else passed++;
      total++; if (io.OK !== (i < NB - 1)) $display("FAIL read_ok[%0d] got %b exp %b", i, io.OK, (i < NB - 1)); else passed++;
      if (i == 5) begin
        io.CMD = 2'b00;
        tick();
        total++; if (io.DOUT !== 8'hA5 || io.OK !== 1'b1) $display("FAIL read_gap dout %h ok %b exp a5/1", io.DOUT, io.OK); else passed++;
      end
    end
    io.CMD = 2'b00;
    tick();
    total++; if (io.DOUT !== 8'hA5 || io.OK !== 1'b0) $display("FAIL read_end dout %h ok %b exp a5/0", io.DOUT, io.OK); else passed++;
  endtask

  task automatic test_abort();
    int st = 0;
    for (int i = 0; i < 7; i++) begin
      io.CMD = 2'b10; io.DIN = 8'(8'h50 + i);
      tick();
    end
    io.CMD = 2'b01; io.DIN = 8'hEE;
    tick();
    total++; if (io.READY !== 1'b1 || io.start !== 1'b0) $display("FAIL abort_ld ready %b start %b exp 1/0", io.READY, io.start); else passed++;
    total++; if (io.key !== 128'h000102030405060708090A0B0C0D0E0F) $display("FAIL abort_key got %h", io.key); else passed++;
    total++; if (io.blk !== 128'h505152535455561718191A1B1C1D1E1F) $display("FAIL abort_partial got %h", io.blk); else passed++;
    io.CMD = 2'b00;
    tick();
    for (int i = 0; i < NB; i++) begin
      io.CMD = 2'b10; io.DIN = 8'(8'h20 + i);
      tick();
      if (io.start === 1'b1) st++;
    end
    io.CMD = 2'b00;
    repeat (2) begin
      tick();
      if (io.start === 1'b1) st++;
    end
    total++; if (st != 1) $display("FAIL abort_start_count got %0d exp 1", st); else passed++;
    total++; if (io.blk !== 128'h202122232425262728292A2B2C2D2E2F) $display("FAIL abort_blk got %h", io.blk); else passed++;
    io.res = 128'h00112233445566778899AABBCCDDEEFF; io.done = 1'b1;
    tick();
    io.done = 1'b0;
    total++; if (io.OK !== 1'b1) $display("FAIL abort_done_ok got %b exp 1", io.OK); else passed++;
    for (int i = 0; i < 3; i++) begin
      io.CMD = 2'b11;
      tick();
      total++; if (io.DOUT !== 8'(i * 17)) $display("FAIL part_read[%0d] got %h exp %h", i, io.DOUT, 8'(i * 17)); else passed++;
    end
    io.CMD = 2'b10;
    tick();
    total++; if (io.OK !== 1'b1 || io.READY !== 1'b1 || io.DOUT !== 8'h22) $display("FAIL read_abort ok %b ready %b dout %h exp 1/1/22", io.OK, io.READY, io.DOUT); else passed++;
    io.CMD = 2'b00;
    tick();
    for (int i = 0; i < NB; i++) begin
      io.CMD = 2'b11;
      tick();
      total++; if (io.DOUT !== 8'(i * 17)) $display("FAIL reread[%0d] got %h exp %h", i, io.DOUT, 8'(i * 17)); else passed++;
    end
    io.CMD = 2'b00;
    tick();
    total++; if (io.OK !== 1'b0) $display("FAIL reread_ok got %b exp 0", io.OK); else passed++;
  endtask

  task automatic test_no_key();
    int st = 0;
    RST_ = 1'b0;
    tick();
    RST_ = 1'b1;
    io.CMD = 2'b00;
    tick();
    for (int i = 0; i < NB; i++) begin
      io.CMD = 2'b10; io.DIN = 8'(i);
      tick();
      if (io.start === 1'b1) st++;
    end
    io.CMD = 2'b00;
    repeat (3) begin
      tick();
      if (io.start === 1'b1) st++;
    end
    total++; if (st != 0) $display("FAIL nokey_start got %0d exp 0", st); else passed++;
    total++; if (io.OK !== 1'b0 || io.READY !== 1'b1) $display("FAIL nokey_state ok %b ready %b exp 0/1", io.OK, io.READY); else passed++;
    total++; if (io.blk !== 128'h000102030405060708090A0B0C0D0E0F) $display("FAIL nokey_blk got %h", io.blk); else passed++;
  endtask

  task automatic test_done_idle();
    io.res = {16{8'hFF}}; io.done = 1'b1;
    tick();
    io.done = 1'b0;
    total++; if (io.OK !== 1'b0) $display("FAIL done_idle_ok got %b exp 0", io.OK); else passed++;
    io.CMD = 2'b11;
    tick();
    io.CMD = 2'b00;
    total++; if (io.DOUT !== 8'h00) $display("FAIL done_idle_dout got %h exp 00", io.DOUT); else passed++;
  endtask

  task automatic test_reset_busy();
    int st = 0;
    for (int i = 0; i < NB; i++) begin
      io.CMD = 2'b01; io.DIN = 8'(i);
      tick();
    end
    for (int i = 0; i < NB; i++) begin
      io.CMD = 2'b10; io.DIN = ~8'(i);
      tick();
    end
    io.CMD = 2'b00;
    tick();
    total++; if (io.READY !== 1'b0) $display("FAIL rb_busy_ready got %b exp 0", io.READY); else passed++;
    RST_ = 1'b0;
    #2;
    total++; if (io.READY !== 1'b1 || io.OK !== 1'b0 || io.key !== '0) $display("FAIL rb_async ready %b ok %b key %h", io.READY, io.OK, io.key); else passed++;
    tick();
    RST_ = 1'b1;
    tick();
    io.res = {16{8'h3C}}; io.done = 1'b1;
    tick();
    io.done = 1'b0;
    total++; if (io.OK !== 1'b0) $display("FAIL rb_done_ok got %b exp 0", io.OK); else passed++;
    repeat (4) begin
      tick();
      if (io.start === 1'b1) st++;
    end
    total++; if (st != 0 || io.READY !== 1'b1) $display("FAIL rb_restart start %0d ready %b exp 0/1", st, io.READY); else passed++;
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_read();
    test_abort();
    test_no_key();
    test_done_idle();
    test_reset_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed %0d total %0d", passed, total);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/aes_io_ctrl.md
# aes_io_ctrl

Byte-serial host-interface controller that sits between the chip pad ring and the AES core. It assembles 128-bit key and plaintext/ciphertext blocks from the 8-bit DIN bus under CMD control and launches the core. It then captures the 128-bit result and streams it back out on DOUT, signalling readiness on READY and result availability on OK.

## Interface
- NBYTES, 16, bytes per block; the key, block and result widths are 8*NBYTES
- CLK  in  1  core clock; all state changes on the rising edge
- RST_  in  1  asynchronous, active-low reset
- CMD  in  2  host command: 00 NOP, 01 LOAD_KEY, 10 LOAD_DATA, 11 READ
- DIN  in  8  host data byte, sampled on CLK when a load command is accepted
- READY  out  1  controller can accept or serve a byte this cycle
- OK  out  1  a completed result is held and not yet fully read
- DOUT  out  8  registered result byte
- key  out  8*NBYTES  assembled key register, to the core
- key_ld  out  1  one-cycle pulse: a new key is complete in `key`
- blk  out  8*NBYTES  assembled data register, to the core
- start  out  1  one-cycle pulse: the core processes `blk` with the current key
- done  in  1  one-cycle pulse from the core: `res` is valid
- res  in  8*NBYTES  core result

## Operation
- States: IDLE, LDKEY, LDDATA, START, BUSY, RD.
- The byte counter `cnt` runs from 0 to NBYTES-1. Byte k maps to bits [8*(NBYTES-k)-1 -: 8], so the first byte is the MSB.
- IDLE:
  - CMD=01 stores DIN as key byte 0, sets cnt=1 and moves to LDKEY.
  - CMD=10 does the same into `blk` and moves to LDDATA.
  - CMD=11 with OK=1 loads DOUT<=res_reg byte 0, sets cnt=1 and moves to RD.
  - CMD=11 with OK=0 is ignored. CMD=00 stays in IDLE.
- LDKEY and LDDATA:
  - A matching CMD stores DIN at byte cnt and increments cnt.
  - CMD=00 pauses; cnt and the registers hold.
  - Any other nonzero CMD aborts: cnt=0, go to IDLE, that DIN is ignored, and partial bytes stay in the register without a pulse.
- LDKEY completion: storing byte NBYTES-1 gives key_ld=1 for the next cycle, sets internal flag `kv` and returns to IDLE.
- LDDATA completion: storing byte NBYTES-1 goes to START if kv=1. If kv=0 it goes to IDLE with no start and no OK.
- START: start=1 for exactly one cycle, then BUSY.
- BUSY: CMD is ignored. When done=1, res is captured into res_reg, OK is set and the state returns to IDLE.
- A done pulse outside BUSY is ignored.
- RD:
  - CMD=11 loads DOUT<=res_reg byte cnt and increments cnt.
  - CMD=00 pauses with DOUT held.
  - Any other nonzero CMD aborts the read: cnt=0, go to IDLE, OK stays 1, and the next read restarts at byte 0.
  - After byte NBYTES-1 is loaded, OK is cleared and the state returns to IDLE.
- A new LOAD_DATA while OK=1 is allowed. The next done overwrites res_reg, and OK stays 1.
- READY = state in {IDLE, LDKEY, LDDATA, RD}, decoded from the state register with no input paths.
- The key persists across blocks; kv is cleared only by reset.

## Timing
- Reset values (RST_ low, asynchronous):
  - State IDLE, so READY=1.
  - OK=0, DOUT=8'h00, key=0, blk=0, key_ld=0, start=0.
  - cnt=0, kv=0, res_reg=0.
- All outputs are registered, except READY, which is a decode of the registered state.
- Load: one byte per cycle; NBYTES consecutive accepted cycles fill a register. key_ld is high the cycle after the edge that samples the last key byte.
- Launch: start is high the cycle after the edge that samples the last data byte, and BUSY begins the cycle after that. READY is 0 from the start cycle until done is seen.
- Completion: done in cycle t gives OK=1 and READY=1 in cycle t+1.
- Read: the byte requested by CMD=11 sampled at edge e is on DOUT after e. OK falls on the same edge that loads the last byte, and DOUT holds that byte afterwards.
- Reset asserted mid-load, mid-BUSY or mid-read returns everything to the reset values immediately. A later done is ignored.

## Test plan
- Reset: RST_ low with CMD=11 -> READY=1, OK=0, DOUT=00. After release, CMD=11 -> ignored, state IDLE.
- Full block: 16×CMD=01 with DIN=00..0F, then 16×CMD=10 with DIN=10..1F:
  - key=00010203..0F and key_ld pulses once.
  - blk=1011..1F, then start pulses once and READY=0.
  - done with res=A5A5..A5 -> OK=1, READY=1.
- Read: 16×CMD=11 -> DOUT=A5 on each cycle after each command, and OK falls with the 16th byte. Insert a CMD=00 gap after byte 5 -> DOUT holds and the sequence resumes at byte 6.
- Abort: 7 bytes of CMD=10 then CMD=01 -> IDLE, no start. Then 16×CMD=10 -> start pulses once and blk holds the new bytes.
- No key: after reset, 16×CMD=10 -> no start, OK=0, READY=1.
- Corner cases:
  - done pulsed in IDLE -> OK stays 0.
  - RST_ low mid-BUSY, then done -> OK=0 and start never re-issues.
